// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequences the PC, reads the combinational instruction
// memory and buffers fetched words in a 2-entry queue toward decode.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_inst,
    output logic [31:0] o_out_pc,
    output logic        o_fetch_fault,
    output logic [31:0] o_fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_q_pc   [2];
    logic [31:0] r_q_inst [2];
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;
    logic        r_fault;
    logic [31:0] r_fetch_count;

    logic w_pc_ok;
    logic w_pop;
    logic w_push;

    assign w_pc_ok = (r_pc[1:0] == 2'b00) && ({2'b00, r_pc[31:2]} < 32'(IMEM_WORDS));
    assign w_pop   = o_out_valid && i_out_ready;
    // A full queue may still accept a push when the head leaves on the same edge.
    assign w_push  = (r_state == RUN) && i_en && !i_redirect_valid && w_pc_ok &&
                     ((r_count < 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_q_pc[0]     <= '0;
            r_q_pc[1]     <= '0;
            r_q_inst[0]   <= '0;
            r_q_inst[1]   <= '0;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_count       <= 2'd0;
            r_fault       <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (i_redirect_valid) begin
                        r_pc <= i_redirect_pc;
                    end
                    r_state <= RUN;
                end
                default: begin
                    if (i_redirect_valid) begin
                        r_head  <= 1'b0;
                        r_tail  <= 1'b0;
                        r_count <= 2'd0;
                        r_pc    <= i_redirect_pc;
                        r_fault <= 1'b0;
                        r_state <= RUN;
                    end else begin
                        if (w_push) begin
                            r_q_pc[r_tail]   <= r_pc;
                            r_q_inst[r_tail] <= i_imem_data;
                            r_tail           <= ~r_tail;
                            r_pc             <= r_pc + 32'd4;
                            r_fetch_count    <= r_fetch_count + 32'd1;
                        end
                        if (w_pop) begin
                            r_head <= ~r_head;
                        end
                        case ({w_push, w_pop})
                            2'b10:   r_count <= r_count + 2'd1;
                            2'b01:   r_count <= r_count - 2'd1;
                            default: r_count <= r_count;
                        endcase
                        if ((r_state == RUN) && i_en && !w_pc_ok) begin
                            r_state <= HALT;
                            r_fault <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_imem_addr   = {2'b00, r_pc[31:2]};
    assign o_out_valid   = (r_count != 2'd0);
    assign o_out_inst    = o_out_valid ? r_q_inst[r_head] : 32'd0;
    assign o_out_pc      = o_out_valid ? r_q_pc[r_head] : 32'd0;
    assign o_fetch_fault = r_fault;
    assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: a queue-based reference model predicts every
// instruction delivered to decode; a negedge monitor pops and compares.
module tb_imem_fetch_ctrl;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_out_inst;
    logic [31:0] o_out_pc;
    logic        o_fetch_fault;
    logic [31:0] o_fetch_count;

    logic [31:0] mem [10];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    bit          m_booted;
    bit          m_halted;
    bit          m_fault;
    ent_t        m_q[$];
    ent_t        exp_q[$];

    imem_fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_en             (i_en),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_addr      (o_imem_addr),
        .i_imem_data      (i_imem_data),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .o_out_inst       (o_out_inst),
        .o_out_pc         (o_out_pc),
        .o_fetch_fault    (o_fetch_fault),
        .o_fetch_count    (o_fetch_count)
    );

    always #5 clk = ~clk;

    assign i_imem_data = (o_imem_addr < 32'd10) ? mem[o_imem_addr[3:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_cnt    = 32'h0;
        m_booted = 1'b0;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        m_q.delete();
        exp_q.delete();
    endtask

    // Effect of one rising edge given the inputs that were present at that edge.
    task automatic model_step(input bit en_v, input bit rv, input logic [31:0] rpc, input bit rdy);
        ent_t ent;
        if (!m_booted) begin
            if (rv) m_pc = rpc;
            m_booted = 1'b1;
            return;
        end
        if (rv) begin
            m_q.delete();
            exp_q.delete();
            m_pc     = rpc;
            m_fault  = 1'b0;
            m_halted = 1'b0;
            return;
        end
        if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
        if (!m_halted && en_v) begin
            if (m_pc % 4 == 0 && m_pc / 4 < 10) begin
                if (m_q.size() < 2) begin
                    ent.pc   = m_pc;
                    ent.inst = mem[m_pc[5:2]];
                    m_q.push_back(ent);
                    exp_q.push_back(ent);
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
            end else begin
                m_halted = 1'b1;
                m_fault  = 1'b1;
            end
        end
    endtask

    task automatic cycle(input bit en_v, input bit rv, input logic [31:0] rpc, input bit rdy);
        i_en             = en_v;
        i_redirect_valid = rv;
        i_redirect_pc    = rpc;
        i_out_ready      = rdy;
        @(posedge clk);
        #1;
        model_step(en_v, rv, rpc, rdy);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_fault", 32'(o_fetch_fault), 32'd0);
        chk("rst_count", o_fetch_count, 32'd0);
        chk("rst_imem_addr", o_imem_addr, 32'd0);
        chk("rst_out_pc", o_out_pc, 32'd0);
        chk("rst_out_inst", o_out_inst, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares every handshake and the persistent status against the model.
    always @(negedge clk) begin
        ent_t e;
        if (rst_n) begin
            chk("out_valid", 32'(o_out_valid), 32'(exp_q.size() != 0));
            chk("imem_addr", o_imem_addr, m_pc >> 2);
            chk("fetch_fault", 32'(o_fetch_fault), 32'(m_fault));
            chk("fetch_count", o_fetch_count, m_cnt);
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop_pc", o_out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", o_out_pc, e.pc);
                    chk("pop_inst", o_out_inst, e.inst);
                end
            end else if (!o_out_valid) begin
                chk("empty_pc", o_out_pc, 32'd0);
                chk("empty_inst", o_out_inst, 32'd0);
            end
        end
    end

    initial begin
        logic [31:0] tgt;
        int          sel;
        mem[0] = 32'h4017D793;
        mem[1] = 32'h0017D793;
        mem[2] = 32'h00179793;
        for (int i = 3; i < 10; i++) mem[i] = 32'h00000033;
        rst_n            = 1'b0;
        i_en             = 1'b0;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = 32'h0;
        i_out_ready      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Free run to the end of memory.
        cycle(1, 0, 0, 1);
        chk("boot_no_valid", 32'(o_out_valid), 32'd0);
        cycle(1, 0, 0, 1);
        chk("first_valid", 32'(o_out_valid), 32'd1);
        chk("first_pc", o_out_pc, 32'd0);
        chk("first_inst", o_out_inst, 32'h4017D793);
        repeat (14) cycle(1, 0, 0, 1);
        chk("halt_fault", 32'(o_fetch_fault), 32'd1);
        chk("halt_count", o_fetch_count, 32'd10);
        chk("halt_addr", o_imem_addr, 32'd10);

        // Misaligned redirect out of HALT, then a good one.
        cycle(1, 1, 32'h6, 1);
        chk("mis_fault_clear", 32'(o_fetch_fault), 32'd0);
        cycle(1, 0, 0, 1);
        chk("mis_fault_set", 32'(o_fetch_fault), 32'd1);
        cycle(1, 1, 32'h4, 1);
        cycle(1, 0, 0, 1);
        chk("redir4_pc", o_out_pc, 32'h4);
        chk("redir4_inst", o_out_inst, 32'h0017D793);
        repeat (3) cycle(1, 0, 0, 1);

        // Backpressure, then redirect while full.
        do_reset();
        repeat (4) cycle(1, 0, 0, 0);
        chk("full_addr", o_imem_addr, 32'd2);
        chk("full_head", o_out_pc, 32'd0);
        cycle(1, 0, 0, 1);
        chk("full_slide_head", o_out_pc, 32'd4);
        chk("full_slide_addr", o_imem_addr, 32'd3);
        cycle(1, 1, 32'h14, 1);
        chk("flush_empty", 32'(o_out_valid), 32'd0);
        cycle(1, 0, 0, 1);
        chk("r14_pc", o_out_pc, 32'h14);
        chk("r14_inst", o_out_inst, 32'h00000033);
        repeat (2) cycle(1, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        repeat (2) cycle(1, 0, 0, 1);

        // Reset in the middle of a full queue.
        do_reset();
        repeat (3) cycle(1, 0, 0, 0);
        chk("mid_full_valid", 32'(o_out_valid), 32'd1);
        do_reset();

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 9) == 0) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)      tgt = 32'(4 * $urandom_range(0, 11));
                else if (sel == 7) tgt = 32'(4 * $urandom_range(0, 9) + $urandom_range(1, 3));
                else if (sel == 8) tgt = 32'hFFFF_FFFC;
                else               tgt = 32'h0;
                cycle($urandom_range(0, 3) != 0, 1, tgt, $urandom_range(0, 1) == 1);
            end else begin
                cycle($urandom_range(0, 4) != 0, 0, 0, $urandom_range(0, 2) != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch controller for the RISC-V core. Sequences the program counter, drives the word index into the combinational-read instruction memory, and buffers fetched instructions in a 2-entry queue toward decode with a valid/ready handshake. Handles branch/jump redirects with flush, stalls on backpressure, and faults on out-of-range or misaligned fetch targets. Sits between the instruction memory and the decode stage.

## Interface

- RESET_PC, 32'h0000_0000: byte address fetched first after reset
- IMEM_WORDS, 10: number of 32-bit words implemented in instruction memory
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  fetch enable; 0 freezes PC and pushes, drain still allowed
- redirect_valid  in  1  load new PC (branch/jump/trap) this cycle
- redirect_pc  in  32  redirect target byte address
- imem_addr  out  32  word index to instruction memory, always pc >> 2
- imem_data  in  32  instruction word returned combinationally for imem_addr
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts head this cycle
- out_inst  out  32  head instruction word
- out_pc  out  32  head byte address
- fetch_fault  out  1  sticky fault: PC out of range or misaligned
- fetch_count  out  32  number of instructions pushed since reset, wraps at 2^32

## Operation

- State machine: BOOT, RUN, HALT. Reset -> BOOT. BOOT -> RUN unconditionally on first clock edge after reset release (no fetch in BOOT; gives memory one cycle to settle).
- RUN: push condition = en && !redirect_valid && pc_ok && (count < 2 || pop). pc_ok = pc[1:0]==0 && (pc>>2) < IMEM_WORDS. On push: entry {pc, imem_data} written to tail, pc <= pc + 4, fetch_count += 1.
- RUN with en && !pc_ok && !redirect_valid -> HALT, fetch_fault <= 1, no push.
- HALT: no pushes, pc held, queue continues draining. Leaves HALT only via redirect.
- Pop = out_valid && out_ready; removes head. Push and pop in same cycle legal at any occupancy, including full (count stays 2).
- Redirect (any state except BOOT): highest priority. Queue cleared (count 0, same-cycle pop/push discarded), pc <= redirect_pc, fetch_fault <= 0, state <= RUN. Target validity is checked on following RUN cycle via pc_ok (bad target -> HALT next cycle). Redirect in BOOT is latched into pc; BOOT -> RUN still occurs.
- Queue: 2 entries, registered; head/tail pointers 1 bit, count 0..2. out_inst/out_pc are 0 when empty.
- PC arithmetic 32-bit, wraps modulo 2^32 (wrapped PC then fails pc_ok).

## Timing

- Reset values: pc = RESET_PC, state BOOT, count 0, out_valid 0, out_inst 0, out_pc 0, fetch_fault 0, fetch_count 0; imem_addr = RESET_PC>>2.
- Reset mid-operation: all state returns to reset values asynchronously; queue contents discarded.
- Reset release -> first push at 2nd rising edge -> out_valid high after that edge (out_valid first observed cycle 2).
- Redirect sampled at edge N -> target pushed at edge N+1 -> out_valid with out_pc = target after N+1. Redirect-to-valid latency 2 cycles.
- Steady state with out_ready=1: one instruction per cycle.
- out_ready=0: queue fills after 2 pushes, pc stops at next unfetched address; resumes same cycle out_ready returns.
- en deassert: takes effect on same edge (no push); en reassert resumes from held pc.

## Test plan

- Bench IMEM model words 0..2 = 32'h4017D793, 32'h0017D793, 32'h00179793, words 3..9 = 32'h00000033; reset release, en=1, out_ready=1 -> out_valid from cycle 2, out_pc 0,4,8,... one per cycle, out_inst matches words in order.
- Run from PC 0 with out_ready=1 -> after word 9 (pc 36) pushed, pc=40 fails range -> fetch_fault=1, HALT, fetch_count=10, no further pushes.
- out_ready=0 from reset -> count saturates at 2 (pcs 0,4), pc=8 held; out_ready=1 for one cycle -> pc 0 popped and pc 8 pushed same edge, count stays 2.
- Redirect to 32'h14 while queue full and out_ready=1 -> queue flushed, 2 cycles later out_pc=32'h14, out_inst=32'h00000033; discarded entries never appear.
- In HALT, redirect to 32'h6 (misaligned) -> fault clears, RUN one cycle, fault reasserts; then redirect to 32'h4 -> out_pc=4, out_inst=32'h0017D793.
- Assert rst_n low mid-stream with count=2 -> out_valid, fetch_fault, fetch_count immediately 0, pc=RESET_PC, imem_addr=0.
